// File: rtl/wb_ctrl.sv
// Writeback controller for the RV32I core.
// Drives the writeback select and the register-file write port. A load is
// sequenced over a req/ack read handshake while the core is stalled. If no
// ack arrives within MAX_WAIT request cycles, the load is dropped and
// load_fault pulses for one cycle.
module wb_ctrl #(
  parameter int unsigned width    = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             reg_write,
  input  logic             is_load,
  input  logic             is_jump,
  input  logic [4:0]       rd_addr,
  input  logic             mem_ack,
  input  logic [width-1:0] mem_rdata,
  output logic             mem_req,
  output logic             stall,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [width-1:0] load_data,
  output logic             load_fault
);

  localparam logic [1:0] SelMem = 2'b00;
  localparam logic [1:0] SelAlu = 2'b01;
  localparam logic [1:0] SelPc4 = 2'b10;
  // Value of the wait count in the last request cycle that may still accept an ack.
  localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

  state_e           state_q;
  logic             mem_req_q;
  logic             load_fault_q;
  logic             ld_we_q;
  logic [4:0]       ld_rd_q;
  logic [7:0]       wait_cnt_q;
  logic [width-1:0] load_data_q;

  logic issue_load;
  logic rd_we_raw;

  // A write to x0 is never enabled.
  assign rd_we_raw  = reg_write && (rd_addr != 5'd0);
  assign issue_load = (state_q == StIdle) && instr_valid && is_load;

  assign mem_req    = mem_req_q;
  assign load_fault = load_fault_q;
  assign load_data  = load_data_q;

  // Load sequencing FSM with its registered handshake and fault outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      load_fault_q <= 1'b0;
      ld_we_q      <= 1'b0;
      ld_rd_q      <= 5'd0;
      wait_cnt_q   <= 8'd0;
      load_data_q  <= '0;
    end else begin
      load_fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (issue_load) begin
            ld_rd_q    <= rd_addr;
            ld_we_q    <= rd_we_raw;
            wait_cnt_q <= 8'd0;
            mem_req_q  <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            load_data_q <= mem_rdata;
            mem_req_q   <= 1'b0;
            state_q     <= StWb;
          end else if (wait_cnt_q == LastWait) begin
            mem_req_q    <= 1'b0;
            load_fault_q <= 1'b1;
            state_q      <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Writeback select, stall and register-file port decode.
  always_comb begin
    wb_sel   = SelAlu;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    stall    = 1'b0;
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          rf_waddr = rd_addr;
          if (is_load) begin
            stall  = 1'b1;
            wb_sel = SelMem;
          end else begin
            wb_sel = is_jump ? SelPc4 : SelAlu;
            rf_we  = rd_we_raw;
          end
        end
      end
      StReq: begin
        stall    = 1'b1;
        wb_sel   = SelMem;
        rf_waddr = ld_rd_q;
      end
      StWb: begin
        wb_sel   = SelMem;
        rf_we    = ld_we_q;
        rf_waddr = ld_rd_q;
      end
      default: begin
        wb_sel = SelAlu;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: a vector table for the single-cycle IDLE
// decode, plus hand-written load, timeout and reset sequences.
module tb_wb_ctrl;

  localparam int unsigned MaxWait = 15;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        reg_write;
  logic        is_load;
  logic        is_jump;
  logic [4:0]  rd_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        stall;
  logic [1:0]  wb_sel;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] load_data;
  logic        load_fault;

  int passed;
  int total;

  wb_ctrl #(
    .width   (32),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .reg_write  (reg_write),
    .is_load    (is_load),
    .is_jump    (is_jump),
    .rd_addr    (rd_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .stall      (stall),
    .wb_sel     (wb_sel),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .load_data  (load_data),
    .load_fault (load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rw;
    logic        jump;
    logic [4:0]  rd;
    logic        ack;
    logic [1:0]  exp_sel;
    logic        exp_we;
    logic [4:0]  exp_waddr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0;
    reg_write   = 1'b0;
    is_load     = 1'b0;
    is_jump     = 1'b0;
    rd_addr     = 5'd0;
    mem_ack     = 1'b0;
  endtask

  // Issue one load; ack_at is the 1-based request cycle carrying the ack, 0 for none.
  task automatic run_load(input logic [4:0] rd, input logic rw, input int ack_at,
                          input logic [31:0] data, input logic [31:0] prev_data);
    int  stalls;
    bit  acked;
    @(negedge clk);
    instr_valid = 1'b1;
    is_load     = 1'b1;
    is_jump     = 1'b1;
    reg_write   = rw;
    rd_addr     = rd;
    mem_ack     = 1'b0;
    #2;
    chk("issue_stall", stall, 1);
    chk("issue_wb_sel", wb_sel, 2'b00);
    chk("issue_rf_we", rf_we, 0);
    chk("issue_mem_req", mem_req, 0);
    stalls = 1;
    acked  = 1'b0;
    for (int k = 1; k <= int'(MaxWait); k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      is_load     = 1'b0;
      is_jump     = 1'b0;
      reg_write   = 1'b1;
      rd_addr     = 5'd30;
      mem_ack     = (k == ack_at);
      mem_rdata   = (k == ack_at) ? data : ~data;
      #2;
      chk("req_mem_req", mem_req, 1);
      chk("req_rf_we", rf_we, 0);
      chk("req_wb_sel", wb_sel, 2'b00);
      if (stall === 1'b1) stalls++;
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #2;
    if (acked) begin
      chk("wb_wb_sel", wb_sel, 2'b00);
      chk("wb_rf_we", rf_we, {31'd0, rw && (rd != 5'd0)});
      chk("wb_rf_waddr", rf_waddr, rd);
      chk("wb_stall", stall, 0);
      chk("wb_mem_req", mem_req, 0);
      chk("wb_load_data", load_data, data);
      chk("wb_load_fault", load_fault, 0);
      chk("stall_cycles", stalls, ack_at + 1);
    end else begin
      chk("to_mem_req", mem_req, 0);
      chk("to_load_fault", load_fault, 1);
      chk("to_stall", stall, 0);
      chk("to_rf_we", rf_we, 0);
      chk("to_wb_sel", wb_sel, 2'b01);
      chk("to_load_data", load_data, prev_data);
      chk("to_stall_cycles", stalls, MaxWait + 1);
    end
    @(negedge clk);
    #2;
    chk("post_mem_req", mem_req, 0);
    chk("post_load_fault", load_fault, 0);
    chk("post_stall", stall, 0);
    chk("post_wb_sel", wb_sel, 2'b01);
    chk("post_rf_we", rf_we, 0);
  endtask

  vec_t vecs[8];

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();

    // valid rw jump rd ack -> sel we waddr
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 2'b01, 1'b1, 5'd5};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd1,  1'b0, 2'b10, 1'b1, 5'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 2'b01, 1'b0, 5'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 2'b10, 1'b0, 5'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd12, 1'b0, 2'b01, 1'b0, 5'd12};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 2'b01, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 2'b01, 1'b0, 5'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 5'd31, 1'b0, 2'b01, 1'b1, 5'd31};

    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_wb_sel", wb_sel, 2'b01);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_load_fault", load_fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      instr_valid = vecs[i].valid;
      reg_write   = vecs[i].rw;
      is_jump     = vecs[i].jump;
      is_load     = 1'b0;
      rd_addr     = vecs[i].rd;
      mem_ack     = vecs[i].ack;
      mem_rdata   = 32'h1234_5678;
      #2;
      chk($sformatf("vec%0d_wb_sel", i), wb_sel, vecs[i].exp_sel);
      chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].exp_waddr);
      chk($sformatf("vec%0d_stall", i), stall, 0);
      chk($sformatf("vec%0d_mem_req", i), mem_req, 0);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    chk("stray_ack_load_data", load_data, 0);
    chk("stray_ack_mem_req", mem_req, 0);

    run_load(5'd7, 1'b1, 2, 32'hDEAD_BEEF, 32'h0);
    run_load(5'd0, 1'b1, 1, 32'h0BAD_F00D, 32'hDEAD_BEEF);
    run_load(5'd6, 1'b1, 0, 32'h5555_AAAA, 32'h0BAD_F00D);
    run_load(5'd3, 1'b1, int'(MaxWait), 32'hCAFE_F00D, 32'h0BAD_F00D);

    // Reset in the second request cycle abandons the load.
    @(negedge clk);
    instr_valid = 1'b1;
    is_load     = 1'b1;
    reg_write   = 1'b1;
    rd_addr     = 5'd4;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #2;
    chk("rstreq_mem_req_before", mem_req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstreq_mem_req", mem_req, 0);
    chk("rstreq_stall", stall, 0);
    chk("rstreq_load_data", load_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1;
    reg_write   = 1'b1;
    rd_addr     = 5'd9;
    #2;
    chk("rstadd_rf_we", rf_we, 1);
    chk("rstadd_rf_waddr", rf_waddr, 9);
    chk("rstadd_wb_sel", wb_sel, 2'b01);
    chk("rstadd_stall", stall, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("rstpost_rf_we", rf_we, 0);
    chk("rstpost_mem_req", mem_req, 0);
    chk("rstpost_stall", stall, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
